mode_counter: RTL
=================

// Module: mode_counter
// PURPOSE
//   Parametrised up/down counter with runtime-programmable limit, wrap or
//   saturate mode, parallel load, enable prescaler and terminal-count pulse.
//   Generic timing/sequencing primitive for timers, PWM period generation and
//   cascaded counters. Single clock domain; all state is registered.
// PARAMETERS
//   WIDTH        8    counter and limit width in bits
//   MAX_DEFAULT  255  limit register value after reset; must fit in WIDTH
//   PS_WIDTH     4    prescaler width; step rate = en-cycles / (prescale+1)
// PORTS
//   clk        in   1         rising-edge clock
//   rst        in   1         reset: synchronous, active-high
//   en         in   1         count enable; gates prescaler and counter
//   dir        in   1         1 = count up, 0 = count down
//   mode       in   1         0 = wrap, 1 = saturate
//   load       in   1         parallel load strobe
//   load_val   in   WIDTH     value loaded into out on load
//   max_wr     in   1         limit register write strobe
//   max_val    in   WIDTH     new limit value
//   prescale   in   PS_WIDTH  prescaler divide-by minus one
//   out        out  WIDTH     current count
//   limit      out  WIDTH     current limit register
//   tc         out  1         terminal-count pulse, one cycle, aligned with out
// BEHAVIOUR
//   - Reset (rst=1 at edge): out=0, limit=MAX_DEFAULT, prescaler=0, tc=0.
//     rst overrides every other input; reset mid-count discards all state.
//   - Priority per edge: rst > load > step. max_wr is independent of load/step.
//   - Prescaler: ps_cnt advances only when en=1 and load=0. tick=1 when
//     en=1 and ps_cnt>=prescale; on tick ps_cnt<=0, else ps_cnt<=ps_cnt+1.
//     prescale=0 -> tick every enabled cycle. Lowering prescale below ps_cnt
//     -> tick on next enabled cycle. en=0 -> ps_cnt, out held, tc=0.
//   - step = en & tick & ~load.
//   - Up step: out<limit -> out+1, tc=0. out>=limit -> tc=1 and
//     wrap: out<=0; saturate: out<=limit.
//   - Down step: out==0 -> tc=1 and wrap: out<=limit; saturate: out<=0.
//     out>limit -> out<=limit, tc=0. Otherwise out-1, tc=0.
//   - Step with out already at a saturated boundary re-pulses tc each step.
//   - load: out<=load_val unclamped (may exceed limit; next step resolves per
//     rules above), ps_cnt<=0, tc<=0. One-cycle latency load->out.
//   - max_wr: limit<=max_val next edge; out not modified. A step in the same
//     cycle as max_wr uses the OLD limit.
//   - limit=0: up steps keep out at 0 with tc=1 every step (both modes).
//   - Arithmetic is WIDTH-bit unsigned; +1/-1 never overflow, boundaries above
//     are checked first. tc is registered, never combinational.
//   - dir/mode may change any cycle; sampled only on a step.
// STRUCTURE
//   - counter_pkg: MODE_WRAP=1'b0, MODE_SAT=1'b1, DIR_DOWN=1'b0, DIR_UP=1'b1.
//   - Sub-module en_prescaler (params PS_WIDTH; ports clk, rst, en, clr,
//     prescale, tick) holds ps_cnt. Top holds out, limit, tc, step logic.
// TESTING
//   1 Reset: WIDTH=8, drive rst 1 cycle mid-count at out=37 -> out=0, limit=255,
//     tc=0 next cycle; prescaler restarts from 0.
//   2 Up wrap: max_wr max_val=4, mode=0, dir=1, en=1, prescale=0 -> out 0,1,2,3,4,0;
//     tc=1 only with out=0 after 4.
//   3 Down saturate: load 2, mode=1, dir=0 -> out 1,0,0,0; tc=1 on each step
//     that finds out==0 (2nd and later zeros).
//   4 Prescaler: prescale=2, en=1 continuously -> out increments every 3rd
//     cycle; en=0 for 5 cycles mid-period -> phase preserved on resume.
//   5 Load above limit: limit=10, load 200, dir=1, mode=0 -> next step out=0,
//     tc=1; same with dir=0 -> out=10, tc=0.
//   6 Simultaneous: load=1 and step-eligible -> out=load_val, tc=0; max_wr
//     max_val=3 while out=5 stepping up -> uses old limit 255 -> out=6, then
//     next step out=0 tc=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the mode_counter slice.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg

// File: rtl/en_prescaler.sv
// Enable prescaler: emits one tick every (prescale+1) enabled cycles.
module en_prescaler
    import counter_pkg::*;
#(
    parameter int PS_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic [PS_WIDTH-1:0] prescale,
    output logic                tick
);

    logic [PS_WIDTH-1:0] r_ps_cnt;
    logic                w_at_period;

    // >= rather than == so lowering prescale below the running count
    // produces a tick on the very next enabled cycle.
    assign w_at_period = (r_ps_cnt >= prescale);
    assign tick        = en & w_at_period;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps_cnt <= '0;
        end else if (clr) begin
            r_ps_cnt <= '0;
        end else if (en) begin
            if (w_at_period) begin
                r_ps_cnt <= '0;
            end else begin
                r_ps_cnt <= r_ps_cnt + PS_WIDTH'(1);
            end
        end
    end

endmodule : en_prescaler

// File: rtl/mode_counter.sv
// Up/down counter with programmable limit, wrap/saturate mode, parallel load,
// enable prescaler and registered terminal-count pulse.
module mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_DEFAULT = 255,
    parameter int PS_WIDTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dir,
    input  logic                mode,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                max_wr,
    input  logic [WIDTH-1:0]    max_val,
    input  logic [PS_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]    out,
    output logic [WIDTH-1:0]    limit,
    output logic                tc
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_limit;
    logic             r_tc;

    logic             w_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_next_out;
    logic             w_next_tc;

    en_prescaler #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (w_tick)
    );

    assign w_step = en & w_tick & ~load;

    // Boundaries are resolved before +1/-1, so the arithmetic never wraps.
    always_comb begin
        w_next_out = r_out;
        w_next_tc  = 1'b0;
        if (dir == DIR_UP) begin
            if (r_out >= r_limit) begin
                w_next_tc  = 1'b1;
                w_next_out = (mode == MODE_SAT) ? r_limit : '0;
            end else begin
                w_next_out = r_out + WIDTH'(1);
            end
        end else begin
            if (r_out == '0) begin
                w_next_tc  = 1'b1;
                w_next_out = (mode == MODE_SAT) ? '0 : r_limit;
            end else if (r_out > r_limit) begin
                w_next_out = r_limit;
            end else begin
                w_next_out = r_out - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_out <= load_val;
            r_tc  <= 1'b0;
        end else if (w_step) begin
            r_out <= w_next_out;
            r_tc  <= w_next_tc;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    // The step logic above reads the old limit when max_wr lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_limit <= WIDTH'(MAX_DEFAULT);
        end else if (max_wr) begin
            r_limit <= max_val;
        end
    end

    assign out   = r_out;
    assign limit = r_limit;
    assign tc    = r_tc;

endmodule : mode_counter
